// File: rtl/fetch_unit_pkg.sv
// Shared constants, encodings and condition-code evaluation for the fetch unit.
// Imported by the interface, the branch resolver and the top level.
package fetch_unit_pkg;

    localparam int WORD_W    = 64;
    localparam int INSTR_LEN = 32;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_B     = 3'd1,
        OP_CBZ   = 3'd2,
        OP_CBNZ  = 3'd3,
        OP_BCOND = 3'd4,
        OP_BL    = 3'd5,
        OP_BR    = 3'd6,
        OP_RSVD  = 3'd7
    } branch_op_e;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    typedef enum logic [3:0] {
        CC_EQ = 4'h0, CC_NE = 4'h1, CC_HS = 4'h2, CC_LO = 4'h3,
        CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
        CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB,
        CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF
    } cond_e;

    // LEGv8 condition evaluation on {N,Z,C,V}; AL and NV both mean "always".
    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v, hold;
        {n, z, c, v} = nzcv;
        case (cond_e'(cond))
            CC_EQ:   hold = z;
            CC_NE:   hold = !z;
            CC_HS:   hold = c;
            CC_LO:   hold = !c;
            CC_MI:   hold = n;
            CC_PL:   hold = !n;
            CC_VS:   hold = v;
            CC_VC:   hold = !v;
            CC_HI:   hold = c && !z;
            CC_LS:   hold = !(c && !z);
            CC_GE:   hold = (n == v);
            CC_LT:   hold = (n != v);
            CC_GT:   hold = !z && (n == v);
            CC_LE:   hold = !(!z && (n == v));
            default: hold = 1'b1;
        endcase
        return hold;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: request/address out, acknowledge/data back.
// The fetch unit is the master; the memory model or cache is the slave.
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int WORD = WORD_W
);
    logic                 imem_req;
    logic [WORD-1:0]      imem_addr;
    logic                 imem_ack;
    logic [INSTR_LEN-1:0] imem_rdata;

    modport master (output imem_req, imem_addr, input  imem_ack, imem_rdata);
    modport slave  (input  imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_unit_branch_resolve.sv
// Combinational next-PC selection for the instruction being retired.
// All arithmetic wraps modulo 2^WORD.
module fetch_unit_branch_resolve
    import fetch_unit_pkg::*;
#(
    parameter int WORD = WORD_W
) (
    input  logic [WORD-1:0] pc,
    input  logic [2:0]      branch_op,
    input  logic [WORD-1:0] branch_offset,
    input  logic [WORD-1:0] reg_data,
    input  logic [3:0]      nzcv,
    input  logic [3:0]      cond,
    output logic [WORD-1:0] next_pc,
    output logic            taken
);
    logic [WORD-1:0] seq_pc;
    logic [WORD-1:0] rel_pc;
    logic [WORD-1:0] target;

    assign seq_pc = pc + WORD'(4);
    assign rel_pc = pc + (branch_offset << 2);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        taken  = 1'b0;
        target = rel_pc;
        case (branch_op_e'(branch_op))
            OP_B, OP_BL: taken = 1'b1;
            OP_CBZ:      taken = (reg_data == '0);
            OP_CBNZ:     taken = (reg_data != '0);
            OP_BCOND:    taken = cond_holds(cond, nzcv);
            OP_BR: begin
                taken  = 1'b1;
                target = {reg_data[WORD-1:2], 2'b00};
            end
            default:     taken = 1'b0;
        endcase
    end

    assign next_pc = taken ? target : seq_pc;

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: request, wait for ack, hold the word
// for decode until retire, then resolve the next PC and fetch again.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              WORD     = WORD_W,
    parameter logic [WORD-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    fetch_unit_if.master         imem,
    output logic [INSTR_LEN-1:0] instruction,
    output logic                 instr_valid,
    output logic [WORD-1:0]      pc,
    input  logic                 retire,
    input  logic [2:0]           branch_op,
    input  logic [WORD-1:0]      branch_offset,
    input  logic [WORD-1:0]      reg_data,
    input  logic [3:0]           nzcv,
    output logic [WORD-1:0]      link_addr
);
    state_e          state;
    state_e          state_nxt;
    logic [WORD-1:0] fetch_pc;
    logic [WORD-1:0] next_pc;
    logic            fetching;
    logic            unused_taken;

    assign fetching = (state == ST_REQ) || (state == ST_WAIT);

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_REQ;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_REQ:  state_nxt = imem.imem_ack ? ST_HOLD : ST_WAIT;
            ST_WAIT: if (imem.imem_ack) state_nxt = ST_HOLD;
            ST_HOLD: if (retire)        state_nxt = ST_REQ;
            default: state_nxt = ST_REQ;
        endcase
    end

    // The reset state is REQ, so the request is masked while reset is held.
    always_comb begin
        imem.imem_req  = fetching && !reset;
        imem.imem_addr = fetch_pc;
        instr_valid    = (state == ST_HOLD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            pc          <= RESET_PC;
            instruction <= '0;
        end else if (fetching && imem.imem_ack) begin
            pc          <= fetch_pc;
            instruction <= imem.imem_rdata;
        end else if ((state == ST_HOLD) && retire) begin
            fetch_pc    <= next_pc;
        end
    end

    assign link_addr = pc + WORD'(4);

    // taken is only of interest to trace/prediction logic outside this block.
    fetch_unit_branch_resolve #(.WORD(WORD)) u_branch_resolve (
        .pc            (pc),
        .branch_op     (branch_op),
        .branch_offset (branch_offset),
        .reg_data      (reg_data),
        .nzcv          (nzcv),
        .cond          (instruction[3:0]),
        .next_pc       (next_pc),
        .taken         (unused_taken)
    );

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'd0, PC value loaded on reset.
REQ-002 Parameter WORD, default `WORD (64), address/data width from constants.vh.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 imem_req  output  1  instruction-memory read request, held until imem_ack.
REQ-006 imem_addr  output  WORD  byte address of requested instruction; stable while imem_req=1.
REQ-007 imem_ack  input  1  memory returns imem_rdata this cycle; ignored when imem_req=0.
REQ-008 imem_rdata  input  `INSTR_LEN  fetched instruction word.
REQ-009 instruction  output  `INSTR_LEN  registered instruction presented to decode.
REQ-010 instr_valid  output  1  instruction/pc outputs hold a fetched instruction.
REQ-011 pc  output  WORD  address of the presented instruction.
REQ-012 retire  input  1  decode/execute finished the presented instruction; resolve next PC.
REQ-013 branch_op  input  3  0 none, 1 B, 2 CBZ, 3 CBNZ, 4 B.cond, 5 BL, 6 BR; 7 treated as none.
REQ-014 branch_offset  input  WORD  sign-extended word offset from sign_extender.
REQ-015 reg_data  input  WORD  register operand (CBZ/CBNZ test value, BR target).
REQ-016 nzcv  input  4  status flags {N,Z,C,V}, valid in the retire cycle.
REQ-017 link_addr  output  WORD  pc+4, for BL write to X30.

Function
REQ-018 FSM states: REQ, WAIT, HOLD; reset state REQ.
REQ-019 REQ: imem_req=1, imem_addr=fetch_pc; imem_ack=1 -> capture imem_rdata, go HOLD; else go WAIT.
REQ-020 WAIT: imem_req=1 with unchanged address; imem_ack=1 -> capture, go HOLD; no timeout.
REQ-021 HOLD: instr_valid=1, imem_req=0; outputs frozen until retire=1.
REQ-022 retire=1 in HOLD -> fetch_pc <= next_pc, go REQ next cycle; retire outside HOLD is ignored.
REQ-023 next_pc default pc+4; B and BL: pc+(branch_offset<<2); CBZ taken if reg_data==0; CBNZ taken if reg_data!=0.
REQ-024 B.cond: cond=instruction[3:0], standard LEGv8 EQ..LE evaluation on nzcv; cond 4'hE/4'hF always taken.
REQ-025 BR: next_pc = reg_data with bits[1:0] forced to 0.
REQ-026 All PC arithmetic modulo 2^WORD; wrap-around past all-ones is silent.
REQ-027 link_addr = pc+4 combinationally, independent of branch_op.
REQ-028 Fetch-to-valid latency: one cycle after the imem_ack cycle; minimum REQ->HOLD = 1 cycle.
REQ-029 instr_valid deasserts in the cycle following retire; no bubble-free back-to-back issue.

Reset
REQ-030 Reset asserted: state=REQ, fetch_pc=RESET_PC, pc=RESET_PC, instruction=0, instr_valid=0, imem_req=0 during reset.
REQ-031 Reset mid-WAIT abandons the outstanding request; a late imem_ack after reset is not captured unless it coincides with a new REQ/WAIT.
REQ-032 First request issues on the first clk edge after reset deasserts.

Structure
REQ-033 Branch-op encodings, FSM state encodings and condition-code encodings go in the shared constants.vh with `WORD/`INSTR_LEN.
REQ-034 One sub-module branch_resolve (combinational: pc, branch_op, offset, reg_data, nzcv, cond -> next_pc, taken).

Verification
REQ-035 Reset, imem_ack tied 1 -> imem_addr 0,4,8 on successive fetches with retire pulsed each HOLD.
REQ-036 imem_ack delayed 3 cycles -> imem_addr held constant, instr_valid rises 1 cycle after ack.
REQ-037 pc=0x100, B offset -2 -> next imem_addr 0xF8; BL same -> link_addr 0x104.
REQ-038 CBZ reg_data=0 offset 4 at pc 0x40 -> 0x50; reg_data=5 -> 0x44; CBNZ inverse.
REQ-039 B.cond GE (cond 4'hA) with N=1,V=0 -> not taken, pc+4; N=1,V=1 -> taken.
REQ-040 Reset asserted during WAIT then ack arriving -> outputs stay reset values; fetch restarts at RESET_PC.
